// File: rtl/koopa_sprite_pkg.sv
// Shared geometry, ROM layout constants and animation state type for the koopa sprite renderer.
package koopa_sprite_pkg;
   localparam int SPRITE_W     = 23;
   localparam int SPRITE_H     = 30;
   localparam int FRAME_PIXELS = SPRITE_W * SPRITE_H;
   localparam int NUM_FRAMES   = 14;
   localparam int ADDR_W       = 14;
   localparam logic [5:0] TRANSPARENT_RGB = 6'b110011;

   typedef enum logic {
      PLAY      = 1'b0,
      HOLD_LAST = 1'b1
   } anim_state_t;
endpackage

// File: rtl/koopa_anim_sequencer.sv
// Animation frame sequencer: holds each frame for HOLD_TICKS video frames, loops or stops on the last frame.
module koopa_anim_sequencer
   import koopa_sprite_pkg::*;
#(
   parameter int HOLD_TICKS = 6
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       anim_restart,
   input  logic       loop_en,
   input  logic [3:0] num_frames,
   output logic [3:0] frame_idx,
   output logic       anim_done
);
   localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

   anim_state_t       state_reg;
   logic [HOLD_W-1:0] hold_cnt_reg;
   logic [3:0]        last_idx;

   // A zero-length animation is treated as a single frame.
   assign last_idx = (num_frames == 4'd0) ? 4'd0 : num_frames - 4'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= PLAY;
         hold_cnt_reg <= '0;
         frame_idx    <= '0;
         anim_done    <= 1'b0;
      end else begin
         anim_done <= 1'b0;
         if (anim_restart) begin
            state_reg    <= PLAY;
            hold_cnt_reg <= '0;
            frame_idx    <= '0;
         end else if (state_reg == PLAY && frame_tick) begin
            if (hold_cnt_reg == HOLD_W'(HOLD_TICKS - 1)) begin
               hold_cnt_reg <= '0;
               if (frame_idx < last_idx) begin
                  frame_idx <= frame_idx + 4'd1;
               end else if (loop_en) begin
                  frame_idx <= '0;
               end else begin
                  // Also catches a shrunken animation length: park on the new last frame.
                  frame_idx <= last_idx;
                  anim_done <= 1'b1;
                  state_reg <= HOLD_LAST;
               end
            end else begin
               hold_cnt_reg <= hold_cnt_reg + 1'b1;
            end
         end
      end
   end
endmodule

// File: rtl/koopa_sprite_renderer.sv
// Maps scan position to koopa ROM address, applies mirroring and animation, and gates transparent pixels.
module koopa_sprite_renderer
   import koopa_sprite_pkg::*;
#(
   parameter int HOLD_TICKS = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [9:0]        hcount,
   input  logic [9:0]        vcount,
   input  logic              frame_tick,
   input  logic [9:0]        sprite_x,
   input  logic [9:0]        sprite_y,
   input  logic [3:0]        base_frame,
   input  logic [3:0]        num_frames,
   input  logic              loop_en,
   input  logic              facing_left,
   input  logic              anim_restart,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [5:0]        rom_rgb,
   output logic [5:0]        pixel_rgb,
   output logic              pixel_on,
   output logic              anim_done
);
   logic [9:0] x_reg, y_reg;
   logic [3:0] base_reg, num_reg;
   logic       facing_reg;
   logic [3:0] frame_idx;
   logic       in_box, in_box_d1, in_box_d2;
   logic [9:0] col_raw, row_raw;
   logic [4:0] col, row;
   logic [4:0] frame_sum;
   logic [3:0] frame_sel;
   logic [ADDR_W-1:0] addr_next;

   koopa_anim_sequencer #(.HOLD_TICKS(HOLD_TICKS)) u_seq (
      .clk          (clk),
      .reset        (reset),
      .frame_tick   (frame_tick),
      .anim_restart (anim_restart),
      .loop_en      (loop_en),
      .num_frames   (num_reg),
      .frame_idx    (frame_idx),
      .anim_done    (anim_done)
   );

   // Shadows only move at frame boundaries so a frame is never torn.
   always_ff @(posedge clk) begin
      if (reset) begin
         x_reg      <= '0;
         y_reg      <= '0;
         base_reg   <= '0;
         num_reg    <= '0;
         facing_reg <= 1'b0;
      end else if (frame_tick) begin
         x_reg      <= sprite_x;
         y_reg      <= sprite_y;
         base_reg   <= base_frame;
         num_reg    <= num_frames;
         facing_reg <= facing_left;
      end
   end

   always_comb begin
      in_box = ({1'b0, hcount} >= {1'b0, x_reg}) &&
               ({1'b0, hcount} <  {1'b0, x_reg} + 11'(SPRITE_W)) &&
               ({1'b0, vcount} >= {1'b0, y_reg}) &&
               ({1'b0, vcount} <  {1'b0, y_reg} + 11'(SPRITE_H));
      col_raw   = hcount - x_reg;
      row_raw   = vcount - y_reg;
      col       = facing_reg ? 5'(SPRITE_W - 1) - col_raw[4:0] : col_raw[4:0];
      row       = row_raw[4:0];
      frame_sum = {1'b0, base_reg} + {1'b0, frame_idx};
      frame_sel = (frame_sum > 5'(NUM_FRAMES - 1)) ? 4'(NUM_FRAMES - 1) : frame_sum[3:0];
      addr_next = ADDR_W'(frame_sel) * ADDR_W'(FRAME_PIXELS) +
                  ADDR_W'(row) * ADDR_W'(SPRITE_W) + ADDR_W'(col);
   end

   // in_box is delayed twice so it lines up with the ROM's registered read data.
   always_ff @(posedge clk) begin
      if (reset) begin
         rom_addr  <= '0;
         in_box_d1 <= 1'b0;
         in_box_d2 <= 1'b0;
         pixel_rgb <= '0;
         pixel_on  <= 1'b0;
      end else begin
         rom_addr  <= in_box ? addr_next : '0;
         in_box_d1 <= in_box;
         in_box_d2 <= in_box_d1;
         if (in_box_d2 && rom_rgb != TRANSPARENT_RGB) begin
            pixel_on  <= 1'b1;
            pixel_rgb <= rom_rgb;
         end else begin
            pixel_on  <= 1'b0;
            pixel_rgb <= '0;
         end
      end
   end
endmodule
